// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the sequential bit-index encoder
package enc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int N_DEFAULT = 8;

  // True when exactly one bit is set; callers zero-extend narrower vectors to 64 bits.
  function automatic logic onehot_count_is1(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/enc_scan_prio_enc.sv
// rtl/enc_scan_prio_enc.sv - combinational LSB-first priority encoder
module prio_enc #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk from the top down so the lowest set bit is the last write and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/enc_scan.sv
// rtl/enc_scan.sv - accepts a request vector and emits the index of each set bit, lowest first
module enc_scan
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err
);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_err_q, zero_err_d;
  logic [W-1:0] scan_idx;
  logic         scan_any;
  logic         scan_last;

  prio_enc #(.N(N)) u_prio_enc (
    .vec (pending_q),
    .idx (scan_idx),
    .any (scan_any)
  );

  assign scan_last = onehot_count_is1(64'(pending_q));
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_SCAN) && scan_any;
  assign out_idx   = out_valid ? scan_idx : '0;
  assign out_last  = out_valid && scan_last;
  assign zero_err  = zero_err_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = ST_SCAN;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (out_valid && out_ready) begin
          pending_d = pending_q & ~(N'(1) << scan_idx);
          if (scan_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule
